// File: rtl/adder_seq_pkg.sv
// Shared types and helpers for the multi-cycle carry-select adder.
package adder_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  // Width of the chunk index; a single-chunk adder still needs a 1-bit index.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_carry_select_seq_if.sv
// Request/response handshake bundle for adder_carry_select_seq.
interface adder_carry_select_seq_if #(
  parameter int unsigned p_nbits = 32
) ();

  logic               in_val;
  logic               in_rdy;
  logic [p_nbits-1:0] in0;
  logic [p_nbits-1:0] in1;
  logic               cin;
  logic               sub;
  logic               out_val;
  logic               out_rdy;
  logic [p_nbits-1:0] sum;
  logic               cout;
  logic               ovf;

  modport master (
    output in_val, in0, in1, cin, sub, out_rdy,
    input  in_rdy, out_val, sum, cout, ovf
  );

  modport slave (
    input  in_val, in0, in1, cin, sub, out_rdy,
    output in_rdy, out_val, sum, cout, ovf
  );

endinterface

// File: rtl/adder_chunk_cs.sv
// Combinational carry-select slice adder: ripple lower half, dual-ripple upper half
// selected by the lower carry.
module adder_chunk_cs #(
  parameter int unsigned p_chunk = 8
) (
  input  logic [p_chunk-1:0] a,
  input  logic [p_chunk-1:0] b,
  input  logic               cin,
  output logic [p_chunk-1:0] sum,
  output logic               cout,
  output logic               cmsb
);

  localparam int lo_w = int'(p_chunk) / 2;
  localparam int hi_w = int'(p_chunk) - lo_w;

  logic [lo_w-1:0] s_lo;
  logic [hi_w-1:0] s_hi0;
  logic [hi_w-1:0] s_hi1;
  logic            c_lo;
  logic            c0;
  logic            c1;
  logic            msb_c0;
  logic            msb_c1;
  logic            c;

  always_comb begin
    s_lo   = '0;
    s_hi0  = '0;
    s_hi1  = '0;
    c      = cin;
    c0     = 1'b0;
    c1     = 1'b1;
    msb_c0 = 1'b0;
    msb_c1 = 1'b1;
    for (int i = 0; i < lo_w; i++) begin
      s_lo[i] = a[i] ^ b[i] ^ c;
      c       = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    c_lo = c;
    // Both upper candidates track the carry entering their top bit for overflow.
    for (int i = 0; i < hi_w; i++) begin
      msb_c0   = c0;
      msb_c1   = c1;
      s_hi0[i] = a[lo_w+i] ^ b[lo_w+i] ^ c0;
      c0       = (a[lo_w+i] & b[lo_w+i]) | (c0 & (a[lo_w+i] ^ b[lo_w+i]));
      s_hi1[i] = a[lo_w+i] ^ b[lo_w+i] ^ c1;
      c1       = (a[lo_w+i] & b[lo_w+i]) | (c1 & (a[lo_w+i] ^ b[lo_w+i]));
    end
  end

  assign sum  = {c_lo ? s_hi1 : s_hi0, s_lo};
  assign cout = c_lo ? c1 : c0;
  assign cmsb = c_lo ? msb_c1 : msb_c0;

endmodule

// File: rtl/adder_carry_select_seq.sv
// Multi-cycle adder/subtractor: one p_chunk slice per cycle, LSB slice first,
// with valid/ready on both request and result.
module adder_carry_select_seq
  import adder_seq_pkg::*;
#(
  parameter int unsigned p_nbits = 32,
  parameter int unsigned p_chunk = 8
) (
  input logic                     clk,
  input logic                     reset,
  adder_carry_select_seq_if.slave bus
);

  localparam int unsigned n_chunks = p_nbits / p_chunk;
  localparam int unsigned k_w      = cnt_width(n_chunks);
  localparam logic [k_w-1:0] k_last = k_w'(n_chunks - 1);

  state_e             state_q;
  logic [p_nbits-1:0] a_q;
  logic [p_nbits-1:0] b_q;
  logic [p_nbits-1:0] sum_q;
  logic [k_w-1:0]     k_q;
  logic               carry_q;
  logic               cout_q;
  logic               ovf_q;
  logic               in_rdy_q;
  logic               out_val_q;

  logic [31:0]        base;
  logic [p_chunk-1:0] a_chunk;
  logic [p_chunk-1:0] b_chunk;
  logic [p_chunk-1:0] s_chunk;
  logic               c_out;
  logic               c_msb;

  assign base    = 32'(k_q) * p_chunk;
  assign a_chunk = a_q[base +: p_chunk];
  assign b_chunk = b_q[base +: p_chunk];

  adder_chunk_cs #(
    .p_chunk (p_chunk)
  ) u_chunk (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (carry_q),
    .sum  (s_chunk),
    .cout (c_out),
    .cmsb (c_msb)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      k_q       <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      in_rdy_q  <= 1'b1;
      out_val_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_val) begin
            // Subtract is A + ~B + 1, so the caller's carry-in is dropped.
            a_q      <= bus.in0;
            b_q      <= bus.sub ? ~bus.in1 : bus.in1;
            carry_q  <= bus.sub | bus.cin;
            k_q      <= '0;
            in_rdy_q <= 1'b0;
            state_q  <= StCalc;
          end
        end
        StCalc: begin
          sum_q[base +: p_chunk] <= s_chunk;
          carry_q                <= c_out;
          if (k_q == k_last) begin
            cout_q    <= c_out;
            ovf_q     <= c_msb ^ c_out;
            out_val_q <= 1'b1;
            state_q   <= StDone;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        StDone: begin
          if (bus.out_rdy) begin
            out_val_q <= 1'b0;
            in_rdy_q  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_rdy  = in_rdy_q;
  assign bus.out_val = out_val_q;
  assign bus.sum     = sum_q;
  assign bus.cout    = cout_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_adder_carry_select_seq.sv
// Randomised bench for adder_carry_select_seq at 32/8, 8/8 and 16/2 widths,
// checked against an integer-arithmetic reference model.
module tb_adder_carry_select_seq;

  logic clk;
  logic reset;

  logic        d_val;
  logic [31:0] d_in0;
  logic [31:0] d_in1;
  logic        d_cin;
  logic        d_sub;
  logic        d_ordy;
  int          sel;

  int n_total;
  int n_bad;

  adder_carry_select_seq_if #(.p_nbits(32)) bus32 ();
  adder_carry_select_seq_if #(.p_nbits(8))  bus8 ();
  adder_carry_select_seq_if #(.p_nbits(16)) bus16 ();

  adder_carry_select_seq #(.p_nbits(32), .p_chunk(8)) u_dut32 (
    .clk (clk), .reset (reset), .bus (bus32.slave)
  );
  adder_carry_select_seq #(.p_nbits(8), .p_chunk(8)) u_dut8 (
    .clk (clk), .reset (reset), .bus (bus8.slave)
  );
  adder_carry_select_seq #(.p_nbits(16), .p_chunk(2)) u_dut16 (
    .clk (clk), .reset (reset), .bus (bus16.slave)
  );

  assign bus32.in_val  = d_val && (sel == 0);
  assign bus32.in0     = d_in0;
  assign bus32.in1     = d_in1;
  assign bus32.cin     = d_cin;
  assign bus32.sub     = d_sub;
  assign bus32.out_rdy = d_ordy && (sel == 0);
  assign bus8.in_val   = d_val && (sel == 1);
  assign bus8.in0      = d_in0[7:0];
  assign bus8.in1      = d_in1[7:0];
  assign bus8.cin      = d_cin;
  assign bus8.sub      = d_sub;
  assign bus8.out_rdy  = d_ordy && (sel == 1);
  assign bus16.in_val  = d_val && (sel == 2);
  assign bus16.in0     = d_in0[15:0];
  assign bus16.in1     = d_in1[15:0];
  assign bus16.cin     = d_cin;
  assign bus16.sub     = d_sub;
  assign bus16.out_rdy = d_ordy && (sel == 2);

  logic        obs_rdy;
  logic        obs_val;
  logic [31:0] obs_sum;
  logic        obs_cout;
  logic        obs_ovf;

  always_comb begin
    obs_rdy  = bus32.in_rdy;
    obs_val  = bus32.out_val;
    obs_sum  = bus32.sum;
    obs_cout = bus32.cout;
    obs_ovf  = bus32.ovf;
    if (sel == 1) begin
      obs_rdy  = bus8.in_rdy;
      obs_val  = bus8.out_val;
      obs_sum  = {24'b0, bus8.sum};
      obs_cout = bus8.cout;
      obs_ovf  = bus8.ovf;
    end else if (sel == 2) begin
      obs_rdy  = bus16.in_rdy;
      obs_val  = bus16.out_val;
      obs_sum  = {16'b0, bus16.sum};
      obs_cout = bus16.cout;
      obs_ovf  = bus16.ovf;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int width_of(input int s);
    return (s == 1) ? 8 : (s == 2) ? 16 : 32;
  endfunction

  function automatic int chunks_of(input int s);
    return (s == 1) ? 1 : (s == 2) ? 8 : 4;
  endfunction

  // Plain integer arithmetic: unsigned sum for result/carry, signed sum for overflow.
  task automatic model(input longint a, input longint b, input bit c, input bit s, input int w,
                       output longint es, output bit ec, output bit eo);
    longint mask;
    longint am;
    longint bm;
    longint ci;
    longint full;
    longint sa;
    longint sb;
    longint tot;
    longint half;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    am   = a & mask;
    bm   = s ? (~b & mask) : (b & mask);
    ci   = (s || c) ? 1 : 0;
    full = am + bm + ci;
    es   = full & mask;
    ec   = ((full >> w) & 1) != 0;
    sa   = (am >= half) ? am - (longint'(1) << w) : am;
    sb   = (bm >= half) ? bm - (longint'(1) << w) : bm;
    tot  = sa + sb + ci;
    eo   = (tot >= half) || (tot < -half);
  endtask

  // Called and returns at a negedge. With bp set, new operands are held on the
  // request side during backpressure and left pending on return.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit c, input bit s,
                        input int hold, input bit bp, input logic [31:0] na,
                        input logic [31:0] nb);
    longint es;
    bit     ec;
    bit     eo;
    int     n;
    int     lat;
    model(longint'(a), longint'(b), c, s, width_of(sel), es, ec, eo);
    d_in0 = a;
    d_in1 = b;
    d_cin = c;
    d_sub = s;
    d_val = 1'b1;
    d_ordy = 1'b0;
    n = 0;
    while (!obs_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) check_eq("accept_timeout", 64'(obs_rdy), 64'd1);
    @(posedge clk);
    @(negedge clk);
    d_val = 1'b0;
    d_in0 = $urandom;
    d_in1 = $urandom;
    d_cin = 1'($urandom);
    d_sub = 1'($urandom);
    lat = 0;
    while (!obs_val && lat < 50) begin
      d_ordy = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    d_ordy = 1'b0;
    check_eq("latency", 64'(lat), 64'(chunks_of(sel)));
    check_eq("sum", 64'(obs_sum), 64'(es));
    check_eq("cout", 64'(obs_cout), 64'(ec));
    check_eq("ovf", 64'(obs_ovf), 64'(eo));
    if (bp) begin
      d_val = 1'b1;
      d_in0 = na;
      d_in1 = nb;
      d_cin = 1'b0;
      d_sub = 1'b0;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_val", 64'(obs_val), 64'd1);
      check_eq("hold_sum", 64'(obs_sum), 64'(es));
      check_eq("hold_flags", 64'({obs_cout, obs_ovf}), 64'({ec, eo}));
      if (bp) check_eq("hold_rdy", 64'(obs_rdy), 64'd0);
    end
    d_ordy = 1'b1;
    @(negedge clk);
    d_ordy = 1'b0;
    check_eq("release_val", 64'(obs_val), 64'd0);
    check_eq("release_rdy", 64'(obs_rdy), 64'd1);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    sel     = 0;
    reset   = 1'b0;
    d_val   = 1'b0;
    d_in0   = '0;
    d_in1   = '0;
    d_cin   = 1'b0;
    d_sub   = 1'b0;
    d_ordy  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rdy", 64'(obs_rdy), 64'd1);
    check_eq("rst_val", 64'(obs_val), 64'd0);
    check_eq("rst_sum", 64'(obs_sum), 64'd0);
    check_eq("rst_flags", 64'({obs_cout, obs_ovf}), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    run_op(32'h00000001, 32'h00000001, 1'b0, 1'b0, 0, 1'b0, '0, '0);
    check_eq("basic_sum", 64'(obs_sum), 64'h2);
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1, 1'b0, '0, '0);
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 0, 1'b0, '0, '0);
    run_op(32'd5, 32'd7, 1'b0, 1'b1, 0, 1'b0, '0, '0);
    run_op(32'd7, 32'd5, 1'b0, 1'b1, 0, 1'b0, '0, '0);
    run_op(32'h80000000, 32'd1, 1'b1, 1'b1, 0, 1'b0, '0, '0);

    // Backpressure with a pending request, then that request is taken after release.
    run_op(32'h00001234, 32'h00004321, 1'b1, 1'b0, 3, 1'b1, 32'hCAFE0000, 32'h0000BEEF);
    run_op(32'hCAFE0000, 32'h0000BEEF, 1'b0, 1'b0, 0, 1'b0, '0, '0);

    // Reset two cycles into CALC.
    d_in0 = 32'hAAAAAAAA;
    d_in1 = 32'h55555555;
    d_cin = 1'b1;
    d_sub = 1'b0;
    d_val = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d_val = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_eq("midrst_rdy", 64'(obs_rdy), 64'd1);
    check_eq("midrst_val", 64'(obs_val), 64'd0);
    check_eq("midrst_sum", 64'(obs_sum), 64'd0);
    run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 0, 1'b0, '0, '0);
    check_eq("post_rst_sum", 64'(obs_sum), 64'h23456789);

    for (int i = 0; i < 200; i++) begin
      run_op($urandom, $urandom, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
             1'b0, '0, '0);
    end

    for (int s = 1; s <= 2; s++) begin
      sel = s;
      @(negedge clk);
      run_op(32'hFF, 32'h01, 1'b0, 1'b0, 0, 1'b0, '0, '0);
      run_op(32'h7F, 32'h01, 1'b0, 1'b0, 1, 1'b0, '0, '0);
      run_op(32'h05, 32'h07, 1'b0, 1'b1, 0, 1'b0, '0, '0);
      run_op(32'h8000, 32'h0001, 1'b0, 1'b1, 0, 1'b0, '0, '0);
      run_op(32'hFFFF, 32'h0000, 1'b1, 1'b0, 2, 1'b0, '0, '0);
      for (int i = 0; i < 25; i++) begin
        run_op($urandom, $urandom, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
               1'b0, '0, '0);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
